fuzz_sig_accum: RTL and testbench
=================================

Name: fuzz_sig_accum

Overview:
- Parametrised successor to the single-width fuzz top used in synthesis-vs-simulation bug hunting.
- Accepts NCH signed data channels of width W under a valid qualifier and keeps a DEPTH-deep sliding-window sum per channel.
- Compresses every accepted input word into a SIGW-bit MISR signature over a run of WINDOW samples.
- The signature and windowed sums are the comparison points between pre- and post-synthesis netlists.

Parameters:
- W, 8: width of each channel sample, treated as two's-complement signed.
- NCH, 2: number of channels (≥1).
- DEPTH, 4: sliding-window length per channel (≥2).
- SIGW, 8: MISR and signature width.
- WINDOW, 8: accepted samples per run (≥1).
- POLY, 8'h07: MISR feedback polynomial, SIGW bits.
- SEED, 8'hFF: MISR value loaded at run start, SIGW bits.
- Derived: AW = W + clog2(DEPTH), accumulator width; CW = clog2(WINDOW+1), counter width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: run request, sampled only in IDLE.
- din, input, NCH*W: channel c occupies din[c*W +: W].
- din_valid, input, 1: din is accepted this cycle (meaningful in RUN only).
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse when a run completes.
- sig, output, SIGW: final signature; holds until the next run starts.
- acc_o, output, NCH*AW: signed windowed sum, channel c at acc_o[c*AW +: AW].
- count_o, output, CW: samples accepted in the current run.

Behaviour:
- Reset: sampled only on a clk edge with rst_n=0. Clears state to IDLE and zeroes busy, done, sig, acc_o, count_o, all history registers and the MISR. A reset mid-run abandons the run with no done pulse.
- FSM states and transitions:
  - IDLE: start=1 → RUN. On that edge: MISR ← SEED; history, acc and count ← 0; sig keeps its old value.
  - RUN: busy=1.
    - Each edge with din_valid=1 updates the history, acc, MISR and count.
    - When an accepted sample makes count equal WINDOW → DONE; sig ← MISR next value.
    - din_valid=0 cycles change nothing.
  - DONE: done=1 for exactly one cycle, busy=0; next state is IDLE unconditionally.
- start is ignored in RUN and DONE; no queuing.
- History: per channel, a DEPTH-entry shift register. The new sample enters at index 0 and the entry at DEPTH-1 falls off. Entries are zero after clear.
- Windowed sum: acc[c] ← acc[c] + sext(new) − sext(oldest), computed at AW bits. It always equals the signed sum of the DEPTH stored entries and cannot overflow. acc_o is registered: 1-cycle latency after the accepting edge.
- MISR, per accepted sample:
  - fold = XOR of din split into SIGW-bit chunks from bit 0; the last chunk is zero-padded.
  - misr ← {misr[SIGW-2:0], 1'b0} ^ (misr[SIGW-1] ? POLY : 0) ^ fold.
- count_o increments per accepted sample and reads WINDOW in the DONE cycle. It is cleared on the next start.
- acc_o and history persist after DONE until the next start. din_valid in IDLE or DONE is ignored.
- Loops over channels, depth and fold chunks are static for-loops. Signed/unsigned mixing is explicit (sign-extend before add/sub). No latches, no multi-driven regs.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then 1; start=0 → busy=0, done=0, sig=8'h00, acc_o=0, count_o=0.
2. Zero-data signature, WINDOW=4: start, then din=16'h0000 with din_valid=1 for 4 cycles → MISR FF→F9→F5→ED→DD; done pulses one cycle; sig=8'hDD; count_o=4.
3. Sliding sum, defaults: channel0 fed 8'h80 on 5 consecutive valid cycles → acc_o[9:0] sequence −128, −256, −384, −512, −512 (10'h200). Channel1 is fed 8'h01 → its sum saturates at 4.
4. Valid gaps: defaults, 8 samples interleaved with 8 din_valid=0 cycles → done arrives 16 cycles after start. Sig equals the gap-free run with the same data.
5. Start while busy and reset mid-run: start pulses at sample 3 → no effect. rst_n=0 at sample 5 → next cycle busy=0, sig=0, acc_o=0, no done pulse. A fresh start then completes normally.
6. Width generalisation: W=18, NCH=3, SIGW=32, POLY=32'h04C11DB7, SEED=32'hFFFFFFFF, random data → sig and acc_o match the reference model bit-exactly. Includes the zero-padded last fold chunk (54 bits into two 32-bit chunks).

Source files
------------

// File: rtl/fuzz_sig_accum.sv
// fuzz_sig_accum: per-channel sliding-window sums and a MISR signature over a
// run of WINDOW accepted samples. The signature and the windowed sums are the
// observation points when comparing pre- and post-synthesis netlists.
module fuzz_sig_accum #(
  parameter int              W      = 8,
  parameter int              NCH    = 2,
  parameter int              DEPTH  = 4,
  parameter int              SIGW   = 8,
  parameter int              WINDOW = 8,
  parameter logic [SIGW-1:0] POLY   = 8'h07,
  parameter logic [SIGW-1:0] SEED   = 8'hFF,
  localparam int             AW     = W + $clog2(DEPTH),
  localparam int             CW     = $clog2(WINDOW + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NCH*W-1:0]   din,
  input  logic               din_valid,
  output logic               busy,
  output logic               done,
  output logic [SIGW-1:0]    sig,
  output logic [NCH*AW-1:0]  acc_o,
  output logic [CW-1:0]      count_o
);

  // Input word width, number of SIGW-bit fold chunks, and the padded width
  // that makes the last chunk zero-filled.
  localparam int DW    = NCH * W;
  localparam int NFOLD = (DW + SIGW - 1) / SIGW;
  localparam int PADW  = NFOLD * SIGW;

  localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SIGW-1:0] misr_q, misr_d;
  logic [SIGW-1:0] sig_q;
  logic [CW-1:0]   count_q;
  logic [PADW-1:0] din_pad;
  logic [SIGW-1:0] fold;

  logic start_run;
  logic accept;
  logic last_accept;

  assign start_run   = (state_q == S_IDLE) && start;
  assign accept      = (state_q == S_RUN) && din_valid;
  assign last_accept = accept && (count_q == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE always falls back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_accept) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Fold the whole input word into SIGW bits by XOR of chunks from bit 0.
  assign din_pad = PADW'(din);

  always_comb begin
    fold = '0;
    for (int i = 0; i < NFOLD; i++) begin
      fold = fold ^ din_pad[i*SIGW +: SIGW];
    end
  end

  assign misr_d = {misr_q[SIGW-2:0], 1'b0} ^ (misr_q[SIGW-1] ? POLY : '0) ^ fold;

  // MISR, run counter and captured signature; sig survives run start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misr_q  <= '0;
      sig_q   <= '0;
      count_q <= '0;
    end else if (start_run) begin
      misr_q  <= SEED;
      count_q <= '0;
    end else if (accept) begin
      misr_q  <= misr_d;
      count_q <= count_q + CW'(1);
      if (last_accept) begin
        sig_q <= misr_d;
      end
    end
  end

  assign sig     = sig_q;
  assign count_o = count_q;

  // Per-channel history shift register and running windowed sum.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic        [W-1:0]  hist_q [DEPTH];
      logic        [W-1:0]  new_smp;
      logic        [W-1:0]  old_smp;
      logic signed [AW-1:0] new_ext;
      logic signed [AW-1:0] old_ext;
      logic signed [AW-1:0] acc_q;
      logic signed [AW-1:0] acc_d;

      assign new_smp = din[gi*W +: W];
      assign old_smp = hist_q[DEPTH-1];
      assign new_ext = {{(AW - W){new_smp[W-1]}}, new_smp};
      assign old_ext = {{(AW - W){old_smp[W-1]}}, old_smp};
      // Adding the newcomer and dropping the oldest keeps acc equal to the
      // sum of the DEPTH stored entries, which AW bits always hold.
      assign acc_d   = acc_q + new_ext - old_ext;

      // History and sum are cleared by reset and at every run start.
      always_ff @(posedge clk) begin
        if (!rst_n || start_run) begin
          for (int d = 0; d < DEPTH; d++) begin
            hist_q[d] <= '0;
          end
          acc_q <= '0;
        end else if (accept) begin
          hist_q[0] <= new_smp;
          for (int d = 1; d < DEPTH; d++) begin
            hist_q[d] <= hist_q[d-1];
          end
          acc_q <= acc_d;
        end
      end

      assign acc_o[gi*AW +: AW] = acc_q;
    end
  endgenerate

endmodule

// File: tb/tb_fuzz_sig_accum.sv
// Bench for fuzz_sig_accum: three instances (defaults, WINDOW=4, wide 3x18-bit
// with 32-bit CRC polynomial) share control; a behavioural model built from
// sample lists checks every output on every falling edge.
`timescale 1ns/1ps
module tb_fuzz_sig_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, din_valid;
  logic [15:0] din_ab;
  logic [53:0] din_c;

  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [7:0]  sig_a, sig_b;
  logic [31:0] sig_c;
  logic [19:0] acc_a, acc_b;
  logic [59:0] acc_c;
  logic [3:0]  cnt_a, cnt_c;
  logic [2:0]  cnt_b;

  fuzz_sig_accum dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din_ab), .din_valid(din_valid),
    .busy(busy_a), .done(done_a), .sig(sig_a), .acc_o(acc_a), .count_o(cnt_a)
  );

  fuzz_sig_accum #(.WINDOW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din_ab), .din_valid(din_valid),
    .busy(busy_b), .done(done_b), .sig(sig_b), .acc_o(acc_b), .count_o(cnt_b)
  );

  fuzz_sig_accum #(
    .W(18), .NCH(3), .DEPTH(4), .SIGW(32), .WINDOW(8),
    .POLY(32'h04C11DB7), .SEED(32'hFFFFFFFF)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din_c), .din_valid(din_valid),
    .busy(busy_c), .done(done_c), .sig(sig_c), .acc_o(acc_c), .count_o(cnt_c)
  );

  // Per-instance parameters for the model.
  int          p_w[3]     = '{8, 8, 18};
  int          p_nch[3]   = '{2, 2, 3};
  int          p_depth[3] = '{4, 4, 4};
  int          p_sigw[3]  = '{8, 8, 32};
  int          p_win[3]   = '{8, 4, 8};
  logic [63:0] p_poly[3]  = '{64'h07, 64'h07, 64'h04C11DB7};
  logic [63:0] p_seed[3]  = '{64'hFF, 64'hFF, 64'hFFFFFFFF};

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode[3];   // 0 idle, 1 running, 2 done
  int          m_cnt[3];
  logic [63:0] m_misr[3];
  logic [63:0] m_sig[3];
  longint      smp[3][3][$];

  function automatic logic [63:0] mask(input int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  // Bit b of the word lands on signature bit b mod SIGW.
  function automatic logic [63:0] fold_of(input logic [63:0] d, input int dw, input int sw);
    logic [63:0] f;
    f = '0;
    for (int b = 0; b < dw; b++) f[b % sw] = f[b % sw] ^ d[b];
    return f;
  endfunction

  function automatic logic [63:0] misr_step(input logic [63:0] m, input logic [63:0] d, input int k);
    logic [63:0] n;
    n = (m << 1) & mask(p_sigw[k]);
    if (m[p_sigw[k]-1]) n = n ^ p_poly[k];
    n = n ^ fold_of(d, p_w[k] * p_nch[k], p_sigw[k]);
    return n;
  endfunction

  function automatic longint chan(input logic [63:0] d, input int k, input int c);
    logic [63:0] v;
    longint      s;
    v = (d >> (c * p_w[k])) & mask(p_w[k]);
    s = longint'(v);
    if (v[p_w[k]-1]) s = s - (longint'(1) << p_w[k]);
    return s;
  endfunction

  function automatic logic [63:0] exp_acc(input int k);
    logic [63:0] r;
    longint      s;
    int          aw, n, lo;
    r  = '0;
    aw = p_w[k] + $clog2(p_depth[k]);
    for (int c = 0; c < p_nch[k]; c++) begin
      s  = 0;
      n  = smp[k][c].size();
      lo = (n > p_depth[k]) ? n - p_depth[k] : 0;
      for (int i = lo; i < n; i++) s = s + smp[k][c][i];
      r = r | ((64'(s) & mask(aw)) << (c * aw));
    end
    return r;
  endfunction

  task automatic model_edge(input int k, input logic [63:0] d);
    if (!rst_n) begin
      m_mode[k] = 0; m_cnt[k] = 0; m_misr[k] = '0; m_sig[k] = '0;
      for (int c = 0; c < 3; c++) smp[k][c].delete();
    end else begin
      case (m_mode[k])
        0: if (start) begin
          m_mode[k] = 1; m_cnt[k] = 0; m_misr[k] = p_seed[k];
          for (int c = 0; c < 3; c++) smp[k][c].delete();
        end
        1: if (din_valid) begin
          for (int c = 0; c < p_nch[k]; c++) smp[k][c].push_back(chan(d, k, c));
          m_misr[k] = misr_step(m_misr[k], d, k);
          m_cnt[k]++;
          if (m_cnt[k] == p_win[k]) begin
            m_sig[k]  = m_misr[k];
            m_mode[k] = 2;
          end
        end
        default: m_mode[k] = 0;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, 64'(din_ab));
    model_edge(1, 64'(din_ab));
    model_edge(2, 64'(din_c));
  end

  task automatic get_out(input int k, output logic b, output logic dn,
                         output logic [63:0] sg, output logic [63:0] ac, output logic [63:0] ct);
    case (k)
      0:       begin b = busy_a; dn = done_a; sg = 64'(sig_a); ac = 64'(acc_a); ct = 64'(cnt_a); end
      1:       begin b = busy_b; dn = done_b; sg = 64'(sig_b); ac = 64'(acc_b); ct = 64'(cnt_b); end
      default: begin b = busy_c; dn = done_c; sg = 64'(sig_c); ac = 64'(acc_c); ct = 64'(cnt_c); end
    endcase
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin : cmp
    logic        ob, od;
    logic [63:0] osg, oac, oct;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        get_out(k, ob, od, osg, oac, oct);
        chk($sformatf("inst%0d_busy", k),  64'(ob), 64'(m_mode[k] == 1));
        chk($sformatf("inst%0d_done", k),  64'(od), 64'(m_mode[k] == 2));
        chk($sformatf("inst%0d_sig", k),   osg, m_sig[k]);
        chk($sformatf("inst%0d_acc", k),   oac, exp_acc(k));
        chk($sformatf("inst%0d_count", k), oct, 64'(m_cnt[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rn, input logic s, input logic v, input logic [15:0] d);
    rst_n     = rn;
    start     = s;
    din_valid = v;
    din_ab    = d;
    din_c     = 54'({$urandom(), $urandom()});
    @(posedge clk);
    #2;
  endtask

  logic [9:0]  t3_ch0[5]  = '{10'h380, 10'h300, 10'h280, 10'h200, 10'h200};
  logic [9:0]  t3_ch1[5]  = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd4};
  logic [15:0] t4_data[8] = '{16'h1234, 16'hABCD, 16'h00FF, 16'h8001,
                              16'h7F80, 16'hFFFF, 16'h0F0F, 16'h5AA5};

  initial begin
    logic [63:0] exp_sig;
    logic [63:0] tmp;
    bit          seen;

    rst_n = 1'b0; start = 1'b0; din_valid = 1'b0; din_ab = '0; din_c = '0;

    // Model pins: zero-padded fold and the default MISR chain.
    tmp = mask(54);
    chk("pin_fold54", fold_of(tmp, 54, 32), 64'hFFC00000);
    tmp = 64'hFF;
    tmp = misr_step(tmp, 64'h0, 0);
    chk("pin_misr_step", tmp, 64'hF9);

    // 1. reset then idle
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t1_busy", 64'(busy_a), 64'd0);
    chk("t1_done", 64'(done_a), 64'd0);
    chk("t1_sig",  64'(sig_a),  64'd0);
    chk("t1_acc",  64'(acc_a),  64'd0);
    chk("t1_cnt",  64'(cnt_a),  64'd0);
    chk("t1_sig_c", 64'(sig_c), 64'd0);

    // 2. zero-data signature on the WINDOW=4 instance
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 16'h0000);
    chk("t2_done_b", 64'(done_b), 64'd1);
    chk("t2_sig_b",  64'(sig_b),  64'hDD);
    chk("t2_cnt_b",  64'(cnt_b),  64'd4);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t2_done_b_pulse", 64'(done_b), 64'd0);
    chk("t2_sig_b_hold",   64'(sig_b),  64'hDD);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 16'h0000);
    chk("t2_done_a", 64'(done_a), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);

    // 3. sliding sum saturating at DEPTH entries
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 16'h0180);
      chk($sformatf("t3_acc0_%0d", i), 64'(acc_a[9:0]),   64'(t3_ch0[i]));
      chk($sformatf("t3_acc1_%0d", i), 64'(acc_a[19:10]), 64'(t3_ch1[i]));
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 16'h0180);
    chk("t3_done_a", 64'(done_a), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);

    // 4. valid gaps: done 16 cycles after start, same sig as gap-free data
    exp_sig = 64'hFF;
    for (int i = 0; i < 8; i++) exp_sig = misr_step(exp_sig, 64'(t4_data[i]), 0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 16'hDEAD);
      chk($sformatf("t4_nodone_gap%0d", i), 64'(done_a), 64'd0);
      cyc(1'b1, 1'b0, 1'b1, t4_data[i]);
      if (i < 7) chk($sformatf("t4_nodone_smp%0d", i), 64'(done_a), 64'd0);
    end
    chk("t4_done_at_16", 64'(done_a), 64'd1);
    chk("t4_sig",        64'(sig_a),  exp_sig);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);

    // 5. start while busy, then reset mid-run, then a fresh run
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2)      cyc(1'b1, 1'b1, 1'b1, 16'($urandom()));
      else if (i == 4) cyc(1'b0, 1'b0, 1'b1, 16'($urandom()));
      else             cyc(1'b1, 1'b0, 1'b1, 16'($urandom()));
      if (i == 2) begin
        chk("t5_busy_after_start", 64'(busy_a), 64'd1);
        chk("t5_cnt_after_start",  64'(cnt_a),  64'd3);
      end
    end
    chk("t5_rst_busy", 64'(busy_a), 64'd0);
    chk("t5_rst_sig",  64'(sig_a),  64'd0);
    chk("t5_rst_acc",  64'(acc_a),  64'd0);
    chk("t5_rst_done", 64'(done_a), 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t5_no_done", 64'(done_a), 64'd0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 16'($urandom()));
      if (done_a) seen = 1'b1;
    end
    chk("t5_rerun_done", 64'(seen),  64'd1);
    chk("t5_rerun_cnt",  64'(cnt_a), 64'd8);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);

    // 6. wide instance: random data with scattered gaps
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc(1'b1, 1'b0, 1'(($urandom() % 3) != 0), 16'($urandom()));
      if (done_c) seen = 1'b1;
    end
    chk("t6_done_c", 64'(seen), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 16'($urandom()));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
